mod_m_updown_counter: RTL and testbench

- Parametrised successor to the fixed mod-M up counter.
- Adds:
  - configurable width and modulus;
  - count enable, direction control, synchronous clear and synchronous load;
  - free-running or one-shot mode;
  - terminal-count flags and a registered wrap pulse.
- Serves as the common timebase and event counter for prescalers, baud/tick generators and display multiplexing in the assignment designs.

---
 rtl/mod_m_updown_counter.sv | 138 +++++++++++++
 tb/tb_mod_m_updown_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_m_updown_counter.sv
// mod_m_updown_counter
//   Parametrised modulo-M up/down counter with count enable, synchronous
//   clear and load, free-running or one-shot operation, terminal-count
//   flags and a registered wrap pulse.
//
// Parameters
//   N        counter width in bits
//   M        modulus; count range 0..M-1, legal 2 <= M <= 2**N
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-high reset
//   syn_clr   in   1  synchronous clear to 0 (highest priority)
//   load      in   1  synchronous load of d (saturated to M-1)
//   d         in   N  load value
//   en        in   1  count enable
//   up        in   1  1 = increment, 0 = decrement
//   oneshot   in   1  0 = free-running wrap, 1 = stop at terminal count
//   q         out  N  current count
//   max_tick  out  1  q == M-1 (combinational)
//   min_tick  out  1  q == 0   (combinational)
//   wrap      out  1  one-cycle pulse the cycle after q wraps
//   done      out  1  high while halted at terminal count in one-shot mode
module mod_m_updown_counter #(
  parameter int N = 6,
  parameter int M = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap,
  output logic         done
);

  // M-1 always fits in N bits (M <= 2**N); M itself may not, so the load
  // saturation compare is done one bit wider.
  localparam logic [N-1:0] MAX_VAL = N'(M - 1);
  localparam logic [N:0]   M_EXT   = (N+1)'(M);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_next;
  logic         r_wrap;
  logic         w_wrap_next;
  logic         r_done;
  logic         w_done_next;

  logic         w_at_max;
  logic         w_at_min;
  logic         w_terminal;

  assign w_at_max   = (r_q == MAX_VAL);
  assign w_at_min   = (r_q == '0);
  // Terminal count follows the direction sampled on this edge.
  assign w_terminal = up ? w_at_max : w_at_min;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_q     <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_wrap  <= w_wrap_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_wrap_next  = 1'b0;
    w_done_next  = r_done;

    if (syn_clr) begin
      w_q_next     = '0;
      w_done_next  = 1'b0;
      w_state_next = ST_RUN;
    end else if (load) begin
      w_q_next     = ({1'b0, d} >= M_EXT) ? MAX_VAL : d;
      w_done_next  = 1'b0;
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            if (oneshot && w_terminal) begin
              w_state_next = ST_HALT;
              w_done_next  = 1'b1;
            end else if (up) begin
              // Explicit compare instead of relying on N-bit overflow,
              // so M == 2**N behaves like any other modulus.
              w_q_next    = w_at_max ? '0 : r_q + 1'b1;
              w_wrap_next = w_at_max;
            end else begin
              w_q_next    = w_at_min ? MAX_VAL : r_q - 1'b1;
              w_wrap_next = w_at_min;
            end
          end
        end
        ST_HALT: begin
          // Only leaving one-shot mode releases the halt here; en and up
          // are ignored, and counting resumes on the following edge.
          if (!oneshot) begin
            w_state_next = ST_RUN;
            w_done_next  = 1'b0;
          end
        end
        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

  assign q        = r_q;
  assign max_tick = w_at_max;
  assign min_tick = w_at_min;
  assign wrap     = r_wrap;
  assign done     = r_done;

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// Testbench for mod_m_updown_counter: three instances (M = 15, 64, 2,
// N = 6) share one stimulus stream; a behavioural model pushes expected
// outputs to a scoreboard queue before each edge and they are popped and
// compared just after the edge.
module tb_mod_m_updown_counter;

  localparam int N = 6;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         syn_clr = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] d = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         oneshot = 1'b0;

  logic [N-1:0] q_w [NI];
  logic [NI-1:0] max_w;
  logic [NI-1:0] min_w;
  logic [NI-1:0] wrap_w;
  logic [NI-1:0] done_w;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mod_m_updown_counter #(
        .N(N),
        .M((gi == 0) ? 15 : ((gi == 1) ? 64 : 2))
      ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (syn_clr),
        .load    (load),
        .d       (d),
        .en      (en),
        .up      (up),
        .oneshot (oneshot),
        .q       (q_w[gi]),
        .max_tick(max_w[gi]),
        .min_tick(min_w[gi]),
        .wrap    (wrap_w[gi]),
        .done    (done_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int idx;
    int q;
    bit wrap;
    bit done;
    bit mx;
    bit mn;
  } exp_t;

  exp_t sb[$];

  int mods [NI] = '{15, 64, 2};
  int m_q [NI];
  bit m_halt [NI];
  bit m_done [NI];
  bit m_wrap [NI];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_q[k] = 0;
      m_halt[k] = 1'b0;
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
    end
  endtask

  // Behavioural next-state model for instance k, using the inputs as they
  // stand just before the coming edge.
  task automatic model_edge(input int k);
    int m;
    int term;
    m = mods[k];
    m_wrap[k] = 1'b0;
    if (syn_clr) begin
      m_q[k] = 0;
      m_halt[k] = 1'b0;
      m_done[k] = 1'b0;
    end else if (load) begin
      m_q[k] = (int'(d) >= m) ? m - 1 : int'(d);
      m_halt[k] = 1'b0;
      m_done[k] = 1'b0;
    end else if (m_halt[k]) begin
      if (!oneshot) begin
        m_halt[k] = 1'b0;
        m_done[k] = 1'b0;
      end
    end else if (en) begin
      term = up ? m - 1 : 0;
      if (oneshot && m_q[k] == term) begin
        m_halt[k] = 1'b1;
        m_done[k] = 1'b1;
      end else if (up) begin
        m_wrap[k] = (m_q[k] + 1 == m);
        m_q[k] = (m_q[k] + 1) % m;
      end else begin
        m_wrap[k] = (m_q[k] == 0);
        m_q[k] = (m_q[k] + m - 1) % m;
      end
    end
  endtask

  task automatic cycle(input string name);
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      model_edge(k);
      e.idx  = k;
      e.q    = m_q[k];
      e.wrap = m_wrap[k];
      e.done = m_done[k];
      e.mx   = (m_q[k] == mods[k] - 1);
      e.mn   = (m_q[k] == 0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s.m%0d.q", name, mods[e.idx]), 32'(q_w[e.idx]), 32'(e.q));
      check($sformatf("%s.m%0d.wrap", name, mods[e.idx]), 32'(wrap_w[e.idx]), 32'(e.wrap));
      check($sformatf("%s.m%0d.done", name, mods[e.idx]), 32'(done_w[e.idx]), 32'(e.done));
      check($sformatf("%s.m%0d.max", name, mods[e.idx]), 32'(max_w[e.idx]), 32'(e.mx));
      check($sformatf("%s.m%0d.min", name, mods[e.idx]), 32'(min_w[e.idx]), 32'(e.mn));
    end
    $display("[TB] %-9s q15=%0d q64=%0d q2=%0d wrap=%b done=%b max=%b min=%b",
             name, q_w[0], q_w[1], q_w[2], wrap_w, done_w, max_w, min_w);
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s.m%0d.q", name, mods[k]), 32'(q_w[k]), 32'd0);
      check($sformatf("%s.m%0d.done", name, mods[k]), 32'(done_w[k]), 32'd0);
      check($sformatf("%s.m%0d.wrap", name, mods[k]), 32'(wrap_w[k]), 32'd0);
      check($sformatf("%s.m%0d.max", name, mods[k]), 32'(max_w[k]), 32'd0);
      check($sformatf("%s.m%0d.min", name, mods[k]), 32'(min_w[k]), 32'd1);
    end
    $display("[TB] %-9s q15=%0d q64=%0d q2=%0d done=%b", name, q_w[0], q_w[1], q_w[2], done_w);
  endtask

  // Pulse reset between clock edges (called 1 ns after a rising edge).
  task automatic async_reset(input string name);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state(name);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #20;
    check_reset_state("reset");
    #2;
    reset = 1'b0;

    // free run up: 0..14,0 with one wrap pulse for M=15
    en = 1'b1; up = 1'b1; oneshot = 1'b0;
    repeat (16) cycle("up_run");

    // clear, then count down through the 0 -> M-1 wrap
    syn_clr = 1'b1;
    cycle("clr");
    syn_clr = 1'b0;
    up = 1'b0;
    repeat (4) cycle("down");

    // load, saturating load, load beats enable
    en = 1'b0; load = 1'b1; d = 6'd9;
    cycle("load9");
    en = 1'b1; d = 6'd40;
    cycle("load40");
    load = 1'b0;

    // one-shot from 12 upward, then hold while halted
    load = 1'b1; d = 6'd12;
    cycle("load12");
    load = 1'b0; oneshot = 1'b1; up = 1'b1; en = 1'b1;
    repeat (14) cycle("oneshot");
    up = 1'b0;
    repeat (2) cycle("halt_dir");
    up = 1'b1; oneshot = 1'b0;
    repeat (3) cycle("resume");

    // clear beats load
    syn_clr = 1'b1; load = 1'b1; d = 6'd5;
    cycle("clr_load");
    syn_clr = 1'b0; load = 1'b0;

    // async reset at q = 7
    en = 1'b0; load = 1'b1; d = 6'd7;
    cycle("load7");
    load = 1'b0;
    async_reset("areset7");

    // async reset while halted with done = 1
    en = 1'b1; up = 1'b0; oneshot = 1'b1;
    repeat (2) cycle("halt0");
    async_reset("areset_hlt");
    oneshot = 1'b0;

    // full-range modulus wrap 63 -> 0
    en = 1'b0; load = 1'b1; d = 6'd62;
    cycle("load62");
    load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (4) cycle("edge_m");
    en = 1'b0;
    repeat (2) cycle("hold");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
